// File: rtl/axi_lite_master_port.sv
// AXI4-Lite master port: converts an in-order core request/response interface into
// AXI4-Lite read and write transactions with up to MAX_RD_OUTSTANDING reads in flight.
module axi_lite_master_port #(
    parameter int unsigned ADDR_W             = 32,
    parameter int unsigned DATA_W             = 32,
    parameter int unsigned MAX_RD_OUTSTANDING = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,

    // Core request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    // Core response
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [7:0]          err_count,

    // AXI4-Lite read address / data
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY,

    // AXI4-Lite write address / data / response
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [3:0]  RD_MAX = 4'(MAX_RD_OUTSTANDING);

    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic              awvalid_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              wvalid_q;
    logic              wr_busy_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic [3:0]        rd_cnt_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [7:0]        err_count_q;

    logic rd_accept;
    logic wr_accept;
    logic rsp_free;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic r_hs;
    logic b_hs;
    logic r_err;
    logic b_err;

    // Writes wait for all reads to drain so they never overtake earlier reads.
    assign req_ready = !arvalid_q && !wr_busy_q &&
                       (req_we ? (rd_cnt_q == 4'd0) : (rd_cnt_q < RD_MAX));
    assign rd_accept = req_valid && req_ready && !req_we;
    assign wr_accept = req_valid && req_ready && req_we;

    // The single response register can take a beat when empty or being drained.
    // A stale beat after reset sees RREADY/BREADY low because rd_cnt and the
    // write-done flags are cleared, so it is never accepted.
    assign rsp_free = !rsp_valid_q || rsp_ready;
    assign RREADY   = rsp_free && (rd_cnt_q != 4'd0);
    assign BREADY   = rsp_free && aw_done_q && w_done_q;

    assign ar_hs = arvalid_q && ARREADY;
    assign aw_hs = awvalid_q && AWREADY;
    assign w_hs  = wvalid_q && WREADY;
    assign r_hs  = RVALID && RREADY;
    assign b_hs  = BVALID && BREADY;
    assign r_err = (RRESP != 2'b00);
    assign b_err = (BRESP != 2'b00);

    // Read address channel: latch on acceptance, hold until ARREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else if (rd_accept) begin
            araddr_q  <= req_addr;
            arvalid_q <= 1'b1;
        end else if (ar_hs) begin
            arvalid_q <= 1'b0;
        end
    end

    // Write address/data channels complete independently; B closes the write.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            wr_busy_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (wr_accept) begin
            awaddr_q  <= req_addr;
            awvalid_q <= 1'b1;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            wvalid_q  <= 1'b1;
            wr_busy_q <= 1'b1;
        end else begin
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                wvalid_q <= 1'b0;
                w_done_q <= 1'b1;
            end
            if (b_hs) begin
                wr_busy_q <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

    // Outstanding read count: acceptance and R beat in the same cycle cancel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_cnt_q <= 4'd0;
        end else if (rd_accept && !r_hs) begin
            rd_cnt_q <= rd_cnt_q + 4'd1;
        end else if (r_hs && !rd_accept) begin
            rd_cnt_q <= rd_cnt_q - 4'd1;
        end
    end

    // Response register: load from R or B, otherwise drain on rsp_ready.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (r_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= r_err ? '0 : RDATA;
            rsp_err_q   <= r_err;
        end else if (b_hs) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= b_err;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Saturating count of non-OKAY responses.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_count_q <= 8'd0;
        end else if (((r_hs && r_err) || (b_hs && b_err)) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
    assign busy      = (rd_cnt_q != 4'd0) || wr_busy_q || rsp_valid_q;

endmodule
